// File: rtl/result_output_buffer.sv
// Output-side result FIFO: buffers controller result words and presents the head
// word to the external interface over a valid/ready handshake.
module result_output_buffer #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [DATA_W-1:0] result_data,
    input  logic              result_valid,
    output logic              result_ready,
    output logic [DATA_W-1:0] interface_output,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              buffer_full,
    output logic              buffer_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow_err
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow_err;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == (ADDR_W+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    // A full buffer never accepts, even when the head is popped in the same cycle.
    assign w_push  = result_valid && !w_full;
    assign w_pop   = !w_empty && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_overflow_err <= 1'b0;
        end else if (flush) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_overflow_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (result_valid && w_full) begin
                r_overflow_err <= 1'b1;
            end
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!flush && w_push) begin
            r_mem[r_wr_ptr] <= result_data;
        end
    end

    assign result_ready     = !w_full;
    assign out_valid        = !w_empty;
    assign buffer_full      = w_full;
    assign buffer_empty     = w_empty;
    assign count            = r_count;
    assign overflow_err     = r_overflow_err;
    assign interface_output = w_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: tb/tb_result_output_buffer.sv
// Directed bench for result_output_buffer: queue-based reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_result_output_buffer;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk;
    logic              rst;
    logic              flush;
    logic [DATA_W-1:0] result_data;
    logic              result_valid;
    logic              result_ready;
    logic [DATA_W-1:0] interface_output;
    logic              out_valid;
    logic              out_ready;
    logic              buffer_full;
    logic              buffer_empty;
    logic [ADDR_W:0]   count;
    logic              overflow_err;

    int n_chk  = 0;
    int n_fail = 0;

    result_output_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .result_data      (result_data),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .interface_output (interface_output),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .buffer_full      (buffer_full),
        .buffer_empty     (buffer_empty),
        .count            (count),
        .overflow_err     (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, sticky error as a bit.
    logic [DATA_W-1:0] mq[$];
    bit                merr;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            merr = 1'b0;
        end else if (flush) begin
            mq.delete();
            merr = 1'b0;
        end else begin
            bit was_full;
            bit do_pop;
            was_full = (mq.size() == DEPTH);
            do_pop   = (mq.size() > 0) && out_ready;
            if (result_valid && was_full) merr = 1'b1;
            if (do_pop) void'(mq.pop_front());
            if (result_valid && !was_full) mq.push_back(result_data);
        end
    end

    always @(negedge clk) begin
        logic [DATA_W-1:0] exp_head;
        exp_head = (mq.size() > 0) ? mq[0] : '0;
        chk("m_count",  64'(count), 64'(mq.size()));
        chk("m_empty",  64'(buffer_empty), 64'(mq.size() == 0));
        chk("m_full",   64'(buffer_full), 64'(mq.size() == DEPTH));
        chk("m_valid",  64'(out_valid), 64'(mq.size() != 0));
        chk("m_ready",  64'(result_ready), 64'(mq.size() != DEPTH));
        chk("m_err",    64'(overflow_err), 64'(merr));
        chk("m_data",   interface_output, exp_head);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int recv;
        int cyc;
        bit push_now;
        bit pop_now;

        rst = 1'b0; flush = 1'b0; result_data = '0; result_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(buffer_empty), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(result_ready), 64'd1);
        chk("rst_err",   64'(overflow_err), 64'd0);
        chk("rst_data",  interface_output, 64'd0);
        step();

        // Single-word latency and hold
        result_data = 64'hDEADBEEFCAFEBABE; result_valid = 1'b1;
        step();
        result_valid = 1'b0;
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_data",  interface_output, 64'hDEADBEEFCAFEBABE);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data",  interface_output, 64'hDEADBEEFCAFEBABE);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pop1_empty", 64'(buffer_empty), 64'd1);
        chk("pop1_count", 64'(count), 64'd0);

        // Fill and overflow
        for (int i = 0; i < DEPTH; i++) begin
            result_data = 64'(i); result_valid = 1'b1;
            step();
        end
        result_valid = 1'b0;
        chk("fill_full",  64'(buffer_full), 64'd1);
        chk("fill_count", 64'(count), 64'd64);
        chk("fill_ready", 64'(result_ready), 64'd0);
        chk("fill_err",   64'(overflow_err), 64'd0);
        result_data = 64'h1122334455667788; result_valid = 1'b1;
        step();
        result_valid = 1'b0;
        chk("ovf_err",   64'(overflow_err), 64'd1);
        chk("ovf_count", 64'(count), 64'd64);
        chk("ovf_head",  interface_output, 64'd0);

        // Push and pop together while full: pop happens, push dropped
        result_data = 64'hAAAA_AAAA_AAAA_AAAA; result_valid = 1'b1; out_ready = 1'b1;
        step();
        result_valid = 1'b0; out_ready = 1'b0;
        chk("fpop_count", 64'(count), 64'd63);
        chk("fpop_head",  interface_output, 64'd1);
        for (int i = 1; i < DEPTH; i++) begin
            chk("drain_data", interface_output, 64'(i));
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        chk("drain_empty", 64'(buffer_empty), 64'd1);
        chk("drain_err",   64'(overflow_err), 64'd1);

        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_err", 64'(overflow_err), 64'd0);

        // Wrap-around streaming with random back-pressure
        sent = 0; recv = 0; cyc = 0;
        while (recv < 200 && cyc < 3000) begin
            result_valid = (sent < 200);
            result_data  = 64'h5A00_0000_0000_0000 + 64'(sent);
            out_ready    = ($urandom_range(0, 3) != 0);
            push_now = result_valid && result_ready;
            pop_now  = out_valid && out_ready;
            if (pop_now) chk("stream_data", interface_output, 64'h5A00_0000_0000_0000 + 64'(recv));
            step();
            if (push_now) sent++;
            if (pop_now) recv++;
            cyc++;
            if (count > 7'd64) chk("stream_bound", 64'(count), 64'd64);
        end
        result_valid = 1'b0; out_ready = 1'b0;
        chk("stream_recv", 64'(recv), 64'd200);
        chk("stream_err",  64'(overflow_err), 64'd0);

        // Flush while pushing and popping
        for (int i = 0; i < 10; i++) begin
            result_data = 64'h100 + 64'(i); result_valid = 1'b1;
            step();
        end
        chk("pre_flush_count", 64'(count), 64'd10);
        result_data = 64'hFFFF; result_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
        step();
        result_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_err2",  64'(overflow_err), 64'd0);
        chk("flush_empty", 64'(buffer_empty), 64'd1);
        for (int i = 0; i < 5; i++) begin
            result_data = 64'h200 + 64'(i); result_valid = 1'b1;
            step();
        end
        result_valid = 1'b0;
        chk("refill_count", 64'(count), 64'd5);
        chk("refill_head",  interface_output, 64'h200);

        // Asynchronous reset between edges
        #2 rst = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_empty", 64'(buffer_empty), 64'd1);
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_ready", 64'(result_ready), 64'd1);
        chk("arst_data",  interface_output, 64'd0);
        #2 rst = 1'b1;
        result_data = 64'h77; result_valid = 1'b1;
        step();
        result_valid = 1'b0;
        chk("post_rst_head",  interface_output, 64'h77);
        chk("post_rst_count", 64'(count), 64'd1);

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
